iact_stream_buffer: RTL and testbench



---
 rtl/iact_stream_buffer.sv | 151 +++++++++++++++
 tb/tb_iact_stream_buffer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iact_stream_buffer.sv
// iact_stream_buffer
// Accepts the iact stream selected by the upstream path mux, buffers it in a
// small FIFO and writes the words to consecutive scratchpad addresses. A
// start/length/base-address command launches a transfer; done_o pulses for
// one cycle once the final word has been written.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       synchronous active-low reset
//   start_i      command strobe, honoured only while idle
//   len_i        number of words in the transfer (sampled with start_i)
//   base_addr_i  first scratchpad address (sampled with start_i)
//   data_i       incoming iact word
//   valid_i      data_i is valid
//   ready_o      buffer accepts data_i this cycle
//   wr_en_o      scratchpad write request
//   wr_addr_o    scratchpad write address (base + words written, wrapping)
//   wr_data_o    scratchpad write data (FIFO head)
//   wr_ready_i   scratchpad accepts the write this cycle
//   busy_o       a transfer is in progress (RUN or DONE)
//   done_o       one-cycle completion pulse
//   level_o      current FIFO occupancy
module iact_stream_buffer #(
   parameter int unsigned DATA_WIDTH = 20,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      start_i,
   input  logic [LEN_WIDTH-1:0]      len_i,
   input  logic [ADDR_WIDTH-1:0]     base_addr_i,
   input  logic [DATA_WIDTH-1:0]     data_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   output logic                      wr_en_o,
   output logic [ADDR_WIDTH-1:0]     wr_addr_o,
   output logic [DATA_WIDTH-1:0]     wr_data_o,
   input  logic                      wr_ready_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [$clog2(DEPTH):0]    level_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 r_state;
   logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [LVL_W-1:0]       r_level;
   logic [LEN_WIDTH-1:0]   r_in_cnt;
   logic [LEN_WIDTH-1:0]   r_out_cnt;
   logic [LEN_WIDTH-1:0]   r_len_q;
   logic [ADDR_WIDTH-1:0]  r_base_q;

   logic                   w_run;
   logic                   w_ready;
   logic                   w_wr_en;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_last_pop;

   // Handshake terms are decoded from registers only, so ready_o never
   // depends combinationally on valid_i.
   assign w_run      = (r_state == S_RUN);
   assign w_ready    = w_run && (r_level < LVL_W'(DEPTH)) && (r_in_cnt < r_len_q);
   assign w_wr_en    = w_run && (r_level != '0);
   assign w_push     = valid_i && w_ready;
   assign w_pop      = w_wr_en && wr_ready_i;
   assign w_last_pop = w_pop && ((r_out_cnt + LEN_WIDTH'(1)) == r_len_q);

   // Outputs
   assign ready_o   = w_ready;
   assign wr_en_o   = w_wr_en;
   assign wr_addr_o = r_base_q + ADDR_WIDTH'(r_out_cnt);
   // Head is masked while no write is requested so the bus reads zero at rest.
   assign wr_data_o = w_wr_en ? r_mem[r_rd_ptr] : '0;
   assign busy_o    = (r_state != S_IDLE);
   assign done_o    = (r_state == S_DONE);
   assign level_o   = r_level;

   // FIFO storage; contents need no reset since occupancy is tracked separately
   always_ff @(posedge clk_i) begin
      if (rst_ni && w_push) begin
         r_mem[r_wr_ptr] <= data_i;
      end
   end

   // Control FSM, FIFO pointers, occupancy and transfer counters
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state   <= S_IDLE;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_level   <= '0;
         r_in_cnt  <= '0;
         r_out_cnt <= '0;
         r_len_q   <= '0;
         r_base_q  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_in_cnt <= r_in_cnt + LEN_WIDTH'(1);
         end
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
            r_out_cnt <= r_out_cnt + LEN_WIDTH'(1);
         end

         // Simultaneous push and pop leaves the occupancy unchanged
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase

         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_len_q   <= len_i;
                  r_base_q  <= base_addr_i;
                  r_in_cnt  <= '0;
                  r_out_cnt <= '0;
                  r_state   <= (len_i == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (w_last_pop) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iact_stream_buffer.sv
// Testbench for iact_stream_buffer: queue-based transaction model checked
// against the DUT every cycle, directed scenarios with literal expectations,
// and randomized transfers with a write-order scoreboard.
module tb_iact_stream_buffer;

   localparam int unsigned DW    = 20;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 4;
   localparam int unsigned LW    = AW + 1;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          start_i;
   logic [LW-1:0] len_i;
   logic [AW-1:0] base_addr_i;
   logic [DW-1:0] data_i;
   logic          valid_i;
   logic          ready_o;
   logic          wr_en_o;
   logic [AW-1:0] wr_addr_o;
   logic [DW-1:0] wr_data_o;
   logic          wr_ready_i;
   logic          busy_o;
   logic          done_o;
   logic [$clog2(DEPTH):0] level_o;

   iact_stream_buffer #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
      .base_addr_i(base_addr_i), .data_i(data_i), .valid_i(valid_i),
      .ready_o(ready_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
      .wr_data_o(wr_data_o), .wr_ready_i(wr_ready_i), .busy_o(busy_o),
      .done_o(done_o), .level_o(level_o)
   );

   always #5 clk_i = ~clk_i;

   // Counters
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Stimulus knobs
   logic          t_rst   = 1'b0;
   logic          t_start = 1'b0;
   int            t_len   = 0;
   int            t_base  = 0;
   logic          t_valid = 1'b0;
   logic          t_wrdy  = 1'b0;
   logic [DW-1:0] words[$];
   int            n_push  = 0;
   int            first_push_cyc = -1;
   int            done_cyc = -1;

   // Observed scratchpad writes
   int            log_addr[$];
   logic [DW-1:0] log_data[$];
   int            log_cyc[$];

   // Transaction-level model: 0 idle, 1 run, 2 done
   int            m_mode = 0;
   logic [DW-1:0] m_q[$];
   int            m_acc  = 0;
   int            m_wrc  = 0;
   int            m_len  = 0;
   int            m_base = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      bit push, pop;
      if (!rst_ni) begin
         m_mode = 0; m_q.delete(); m_acc = 0; m_wrc = 0; m_len = 0; m_base = 0;
         return;
      end
      case (m_mode)
         0: if (start_i) begin
               m_len  = int'(len_i);
               m_base = int'(base_addr_i);
               m_acc  = 0;
               m_wrc  = 0;
               m_mode = (m_len == 0) ? 2 : 1;
            end
         1: begin
               push = valid_i && (m_q.size() < DEPTH) && (m_acc < m_len);
               pop  = (m_q.size() > 0) && wr_ready_i;
               if (pop) begin
                  m_q.delete(0);
                  m_wrc++;
               end
               if (push) begin
                  m_q.push_back(data_i);
                  m_acc++;
                  n_push++;
                  if (first_push_cyc < 0) first_push_cyc = cyc;
               end
               if (m_wrc == m_len) m_mode = 2;
            end
         default: m_mode = 0;
      endcase
   endtask

   task automatic compare();
      bit exp_wren;
      exp_wren = (m_mode == 1) && (m_q.size() > 0);
      chk("ready_o", ready_o, (m_mode == 1) && (m_q.size() < DEPTH) && (m_acc < m_len));
      chk("wr_en_o", wr_en_o, exp_wren);
      chk("wr_addr_o", wr_addr_o, (m_base + m_wrc) % (1 << AW));
      if (exp_wren) chk("wr_data_o", wr_data_o, m_q[0]);
      chk("busy_o", busy_o, m_mode != 0);
      chk("done_o", done_o, m_mode == 2);
      chk("level_o", level_o, m_q.size());
   endtask

   // One clock cycle: apply inputs, log handshakes, advance model, check.
   task automatic step();
      rst_ni      = t_rst;
      start_i     = t_start;
      len_i       = LW'(t_len);
      base_addr_i = AW'(t_base);
      wr_ready_i  = t_wrdy;
      valid_i     = t_valid && (n_push < words.size());
      data_i      = (n_push < words.size()) ? words[n_push] : '0;
      if (rst_ni && wr_en_o && wr_ready_i) begin
         log_addr.push_back(int'(wr_addr_o));
         log_data.push_back(wr_data_o);
         log_cyc.push_back(cyc);
      end
      model_step();
      @(posedge clk_i);
      @(negedge clk_i);
      cyc++;
      if (done_o) done_cyc = cyc;
      compare();
   endtask

   task automatic new_test();
      log_addr.delete(); log_data.delete(); log_cyc.delete();
      words.delete();
      n_push = 0;
      first_push_cyc = -1;
      done_cyc = -1;
   endtask

   task automatic begin_xfer(input int len, input int base);
      t_start = 1'b1; t_len = len; t_base = base;
      step();
      t_start = 1'b0;
   endtask

   task automatic run_to_idle();
      int k;
      k = 0;
      while (m_mode != 0 && k < 300) begin
         step();
         k++;
      end
      chk("xfer_timeout", m_mode, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      t_rst = 1'b0;
      step();
      step();
      chk("rst_ready", ready_o, 0);
      chk("rst_wr_en", wr_en_o, 0);
      chk("rst_wr_addr", wr_addr_o, 0);
      chk("rst_wr_data", wr_data_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_level", level_o, 0);
      t_rst = 1'b1;
      step();

      // Basic transfer
      new_test();
      words = '{20'hAAAAA, 20'h12345, 20'h0000F};
      t_valid = 1'b1; t_wrdy = 1'b1;
      begin_xfer(3, 2);
      run_to_idle();
      chk("t1_nwr", log_addr.size(), 3);
      if (log_addr.size() == 3) begin
         chk("t1_addr0", log_addr[0], 2);
         chk("t1_addr1", log_addr[1], 3);
         chk("t1_addr2", log_addr[2], 4);
         chk("t1_data0", log_data[0], 20'hAAAAA);
         chk("t1_data1", log_data[1], 20'h12345);
         chk("t1_data2", log_data[2], 20'h0000F);
         chk("t1_first_lat", log_cyc[0], first_push_cyc + 1);
         chk("t1_consec1", log_cyc[1], log_cyc[0] + 1);
         chk("t1_consec2", log_cyc[2], log_cyc[0] + 2);
         chk("t1_done_cyc", done_cyc, log_cyc[2] + 1);
      end
      chk("t1_busy_end", busy_o, 0);

      // Backpressure
      new_test();
      for (int i = 0; i < 6; i++) words.push_back(DW'(32'h100 + i));
      t_valid = 1'b1; t_wrdy = 1'b0;
      begin_xfer(6, 0);
      for (int i = 0; i < 7; i++) step();
      chk("t2_pushes", n_push, 4);
      chk("t2_level", level_o, 4);
      chk("t2_ready", ready_o, 0);
      chk("t2_wr_en", wr_en_o, 1);
      chk("t2_addr", wr_addr_o, 0);
      chk("t2_data", wr_data_o, 20'h00100);
      step();
      chk("t2_addr_hold", wr_addr_o, 0);
      chk("t2_data_hold", wr_data_o, 20'h00100);
      t_wrdy = 1'b1;
      run_to_idle();
      chk("t2_nwr", log_addr.size(), 6);
      for (int i = 0; i < log_addr.size() && i < 6; i++) begin
         chk("t2_wr_addr", log_addr[i], i);
         chk("t2_wr_data", log_data[i], DW'(32'h100 + i));
      end

      // Length limit
      new_test();
      for (int i = 0; i < 5; i++) words.push_back(DW'(32'h200 + i));
      t_valid = 1'b1; t_wrdy = 1'b1;
      begin_xfer(2, 9);
      run_to_idle();
      chk("t3_pushes", n_push, 2);
      chk("t3_nwr", log_addr.size(), 2);

      // Zero length
      new_test();
      begin_xfer(0, 7);
      chk("t3z_done", done_o, 1);
      chk("t3z_busy", busy_o, 1);
      chk("t3z_ready", ready_o, 0);
      step();
      chk("t3z_done_clr", done_o, 0);
      chk("t3z_nwr", log_addr.size(), 0);

      // Address wrap
      new_test();
      for (int i = 0; i < 4; i++) words.push_back(DW'(32'h5A000 + i));
      begin_xfer(4, 14);
      run_to_idle();
      chk("t4_nwr", log_addr.size(), 4);
      if (log_addr.size() == 4) begin
         chk("t4_addr0", log_addr[0], 14);
         chk("t4_addr1", log_addr[1], 15);
         chk("t4_addr2", log_addr[2], 0);
         chk("t4_addr3", log_addr[3], 1);
      end

      // Start ignored while running
      new_test();
      for (int i = 0; i < 5; i++) words.push_back(DW'(32'h300 + i));
      begin_xfer(3, 5);
      t_start = 1'b1; t_len = 5; t_base = 9;
      step();
      t_start = 1'b0;
      run_to_idle();
      chk("t5_pushes", n_push, 3);
      chk("t5_nwr", log_addr.size(), 3);
      if (log_addr.size() == 3) begin
         chk("t5_addr0", log_addr[0], 5);
         chk("t5_addr2", log_addr[2], 7);
      end

      // Reset mid-transfer
      new_test();
      for (int i = 0; i < 3; i++) words.push_back(DW'(32'h400 + i));
      t_wrdy = 1'b0;
      begin_xfer(6, 0);
      for (int i = 0; i < 4; i++) step();
      chk("t6_level", level_o, 3);
      t_rst = 1'b0;
      step();
      t_rst = 1'b1;
      chk("t6_ready", ready_o, 0);
      chk("t6_wr_en", wr_en_o, 0);
      chk("t6_addr", wr_addr_o, 0);
      chk("t6_data", wr_data_o, 0);
      chk("t6_busy", busy_o, 0);
      chk("t6_done", done_o, 0);
      chk("t6_level0", level_o, 0);
      new_test();
      words = '{20'h4A4A4, 20'h0BEEF};
      t_wrdy = 1'b1;
      begin_xfer(2, 1);
      run_to_idle();
      chk("t6_nwr", log_addr.size(), 2);
      if (log_addr.size() == 2) begin
         chk("t6_addr0", log_addr[0], 1);
         chk("t6_addr1", log_addr[1], 2);
         chk("t6_data0", log_data[0], 20'h4A4A4);
         chk("t6_data1", log_data[1], 20'h0BEEF);
      end

      // Randomized transfers with write-order scoreboard
      for (int x = 0; x < 40; x++) begin
         int len, base, k;
         new_test();
         len  = int'($urandom_range(0, 12));
         base = int'($urandom_range(0, 15));
         for (int i = 0; i < len + int'($urandom_range(0, 3)); i++)
            words.push_back(DW'($urandom));
         t_valid = 1'b1; t_wrdy = 1'b1;
         begin_xfer(len, base);
         k = 0;
         while (m_mode != 0 && k < 300) begin
            t_valid = ($urandom_range(0, 9) < 7);
            t_wrdy  = ($urandom_range(0, 9) < 7);
            t_start = ($urandom_range(0, 9) == 0);
            t_len   = int'($urandom_range(0, 31));
            t_base  = int'($urandom_range(0, 15));
            step();
            k++;
         end
         t_start = 1'b0;
         chk("rnd_timeout", m_mode, 0);
         chk("rnd_nwr", log_addr.size(), len);
         for (int i = 0; i < log_addr.size() && i < len; i++) begin
            chk("rnd_addr", log_addr[i], (base + i) % (1 << AW));
            chk("rnd_data", log_data[i], words[i]);
         end
         t_valid = 1'b0;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
